// File: rtl/aukv_pkg.sv
// Shared types and constants for the Auk-V ID/EX operand stage.
// No logic, so no latency or backpressure of its own.
package aukv_pkg;

    localparam int CTRL_W_DEF = 16;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_EX  = 2'd3
    } fwd_src_e;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        logic [31:0] rs1_dat;
        logic [31:0] rs2_dat;
        logic [31:0] imm;
        logic [4:0]  rd_addr;
        logic        rd_we;
        logic        is_load;
    } idex_t;

endpackage

// File: rtl/aukv_fwd_sel.sv
// Per-operand forwarding select: x0, then EX, MEM, WB, else register file.
// Purely combinational, 0 cycles; it has no handshake and cannot be held off.
module aukv_fwd_sel
    import aukv_pkg::*;
(
    input  logic [4:0]  rs_addr,
    input  logic [31:0] rf_dat,
    input  logic        ex_fwd_en,
    input  logic [4:0]  ex_rd_addr,
    input  logic [31:0] ex_rd_dat,
    input  logic        mem_rd_we,
    input  logic [4:0]  mem_rd_addr,
    input  logic [31:0] mem_rd_dat,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd_addr,
    input  logic [31:0] wb_rd_dat,
    output fwd_src_e    src,
    output logic [31:0] opnd_dat
);

    always_comb begin
        src      = FWD_RF;
        opnd_dat = rf_dat;
        if (rs_addr == REG_ZERO) begin
            src      = FWD_RF;
            opnd_dat = 32'd0;
        end else if (ex_fwd_en && ex_rd_addr == rs_addr) begin
            src      = FWD_EX;
            opnd_dat = ex_rd_dat;
        end else if (mem_rd_we && mem_rd_addr == rs_addr) begin
            src      = FWD_MEM;
            opnd_dat = mem_rd_dat;
        end else if (wb_we && wb_rd_addr == rs_addr) begin
            src      = FWD_WB;
            opnd_dat = wb_rd_dat;
        end
    end

endmodule

// File: rtl/aukv_operand_stage.sv
// ID/EX operand stage: forwarding, load-use bubble, ID/EX register, bubble counter.
// Operands resolve in the ID cycle and land in ID/EX after 1 cycle; i_ex_stall holds ID/EX, flush overrides everything.
module aukv_operand_stage
    import aukv_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_id_valid,
    input  logic [31:0]       i_id_pc,
    input  logic [4:0]        i_id_rs1_addr,
    input  logic [4:0]        i_id_rs2_addr,
    input  logic              i_id_uses_rs1,
    input  logic              i_id_uses_rs2,
    input  logic [4:0]        i_id_rd_addr,
    input  logic              i_id_rd_we,
    input  logic              i_id_is_load,
    input  logic [31:0]       i_id_imm,
    input  logic [CTRL_W-1:0] i_id_ctrl,
    output logic [4:0]        o_rs1_addr,
    output logic [4:0]        o_rs2_addr,
    input  logic [31:0]       i_rs1data,
    input  logic [31:0]       i_rs2data,
    input  logic [4:0]        i_mem_rd_addr,
    input  logic              i_mem_rd_we,
    input  logic [31:0]       i_mem_rd_data,
    input  logic [4:0]        i_wb_rd_addr,
    input  logic              i_wb_we,
    input  logic [31:0]       i_wb_rd_data,
    input  logic [31:0]       i_ex_rd_data,
    input  logic              i_ex_stall,
    input  logic              i_flush,
    output logic              o_id_stall,
    output logic              o_ex_valid,
    output logic [31:0]       o_ex_pc,
    output logic [31:0]       o_ex_rs1data,
    output logic [31:0]       o_ex_rs2data,
    output logic [31:0]       o_ex_imm,
    output logic [4:0]        o_ex_rd_addr,
    output logic              o_ex_rd_we,
    output logic              o_ex_is_load,
    output logic [CTRL_W-1:0] o_ex_ctrl,
    output logic [15:0]       o_hazard_cnt
);

    idex_t             idex_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [15:0]       hazard_cnt;
    logic              ex_fwd_en;
    logic              hazard;
    logic              bubble;
    logic [31:0]       rs1_dat;
    logic [31:0]       rs2_dat;
    fwd_src_e          rs1_src;
    fwd_src_e          rs2_src;

    assign o_rs1_addr = i_id_rs1_addr;
    assign o_rs2_addr = i_id_rs2_addr;

    // A load in EX has no result yet; only MEM can supply its data.
    assign ex_fwd_en = idex_q.vld & idex_q.rd_we & ~idex_q.is_load;

    aukv_fwd_sel u_fwd_rs1 (
        .rs_addr     (i_id_rs1_addr),
        .rf_dat      (i_rs1data),
        .ex_fwd_en   (ex_fwd_en),
        .ex_rd_addr  (idex_q.rd_addr),
        .ex_rd_dat   (i_ex_rd_data),
        .mem_rd_we   (i_mem_rd_we),
        .mem_rd_addr (i_mem_rd_addr),
        .mem_rd_dat  (i_mem_rd_data),
        .wb_we       (i_wb_we),
        .wb_rd_addr  (i_wb_rd_addr),
        .wb_rd_dat   (i_wb_rd_data),
        .src         (rs1_src),
        .opnd_dat    (rs1_dat)
    );

    aukv_fwd_sel u_fwd_rs2 (
        .rs_addr     (i_id_rs2_addr),
        .rf_dat      (i_rs2data),
        .ex_fwd_en   (ex_fwd_en),
        .ex_rd_addr  (idex_q.rd_addr),
        .ex_rd_dat   (i_ex_rd_data),
        .mem_rd_we   (i_mem_rd_we),
        .mem_rd_addr (i_mem_rd_addr),
        .mem_rd_dat  (i_mem_rd_data),
        .wb_we       (i_wb_we),
        .wb_rd_addr  (i_wb_rd_addr),
        .wb_rd_dat   (i_wb_rd_data),
        .src         (rs2_src),
        .opnd_dat    (rs2_dat)
    );

    assign hazard = idex_q.vld & idex_q.is_load & idex_q.rd_we &
                    (idex_q.rd_addr != REG_ZERO) & i_id_valid &
                    ((i_id_uses_rs1 & (i_id_rs1_addr == idex_q.rd_addr)) |
                     (i_id_uses_rs2 & (i_id_rs2_addr == idex_q.rd_addr)));

    assign o_id_stall = ~i_flush & (i_ex_stall | hazard);
    assign bubble     = ~i_flush & ~i_ex_stall & hazard;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            idex_q     <= '0;
            ctrl_q     <= '0;
            hazard_cnt <= 16'd0;
        end else begin
            if (i_flush) begin
                idex_q <= '0;
                ctrl_q <= '0;
            end else if (i_ex_stall) begin
                idex_q <= idex_q;
                ctrl_q <= ctrl_q;
            end else if (hazard) begin
                idex_q.vld <= 1'b0;
            end else begin
                idex_q.vld     <= i_id_valid;
                idex_q.pc      <= i_id_pc;
                idex_q.rs1_dat <= rs1_dat;
                idex_q.rs2_dat <= rs2_dat;
                idex_q.imm     <= i_id_imm;
                idex_q.rd_addr <= i_id_rd_addr;
                idex_q.rd_we   <= i_id_rd_we;
                idex_q.is_load <= i_id_is_load;
                ctrl_q         <= i_id_ctrl;
            end
            if (bubble && hazard_cnt != 16'hFFFF)
                hazard_cnt <= hazard_cnt + 16'd1;
        end
    end

    assign o_ex_valid   = idex_q.vld;
    assign o_ex_pc      = idex_q.pc;
    assign o_ex_rs1data = idex_q.rs1_dat;
    assign o_ex_rs2data = idex_q.rs2_dat;
    assign o_ex_imm     = idex_q.imm;
    assign o_ex_rd_addr = idex_q.rd_addr;
    assign o_ex_rd_we   = idex_q.rd_we;
    assign o_ex_is_load = idex_q.is_load;
    assign o_ex_ctrl    = ctrl_q;
    assign o_hazard_cnt = hazard_cnt;

endmodule

// File: tb/tb_aukv_operand_stage.sv
// Directed bench for aukv_operand_stage with hand-computed expectations.
module tb_aukv_operand_stage;

    localparam int CTRL_W = 16;

    logic              i_clk = 1'b0;
    logic              i_rstn;
    logic              i_id_valid;
    logic [31:0]       i_id_pc;
    logic [4:0]        i_id_rs1_addr, i_id_rs2_addr;
    logic              i_id_uses_rs1, i_id_uses_rs2;
    logic [4:0]        i_id_rd_addr;
    logic              i_id_rd_we, i_id_is_load;
    logic [31:0]       i_id_imm;
    logic [CTRL_W-1:0] i_id_ctrl;
    logic [4:0]        o_rs1_addr, o_rs2_addr;
    logic [31:0]       i_rs1data, i_rs2data;
    logic [4:0]        i_mem_rd_addr;
    logic              i_mem_rd_we;
    logic [31:0]       i_mem_rd_data;
    logic [4:0]        i_wb_rd_addr;
    logic              i_wb_we;
    logic [31:0]       i_wb_rd_data;
    logic [31:0]       i_ex_rd_data;
    logic              i_ex_stall, i_flush;
    logic              o_id_stall, o_ex_valid;
    logic [31:0]       o_ex_pc, o_ex_rs1data, o_ex_rs2data, o_ex_imm;
    logic [4:0]        o_ex_rd_addr;
    logic              o_ex_rd_we, o_ex_is_load;
    logic [CTRL_W-1:0] o_ex_ctrl;
    logic [15:0]       o_hazard_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    aukv_operand_stage #(.CTRL_W(CTRL_W)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_id_valid(i_id_valid), .i_id_pc(i_id_pc),
        .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
        .i_id_uses_rs1(i_id_uses_rs1), .i_id_uses_rs2(i_id_uses_rs2),
        .i_id_rd_addr(i_id_rd_addr), .i_id_rd_we(i_id_rd_we),
        .i_id_is_load(i_id_is_load), .i_id_imm(i_id_imm), .i_id_ctrl(i_id_ctrl),
        .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
        .i_rs1data(i_rs1data), .i_rs2data(i_rs2data),
        .i_mem_rd_addr(i_mem_rd_addr), .i_mem_rd_we(i_mem_rd_we), .i_mem_rd_data(i_mem_rd_data),
        .i_wb_rd_addr(i_wb_rd_addr), .i_wb_we(i_wb_we), .i_wb_rd_data(i_wb_rd_data),
        .i_ex_rd_data(i_ex_rd_data), .i_ex_stall(i_ex_stall), .i_flush(i_flush),
        .o_id_stall(o_id_stall), .o_ex_valid(o_ex_valid), .o_ex_pc(o_ex_pc),
        .o_ex_rs1data(o_ex_rs1data), .o_ex_rs2data(o_ex_rs2data), .o_ex_imm(o_ex_imm),
        .o_ex_rd_addr(o_ex_rd_addr), .o_ex_rd_we(o_ex_rd_we), .o_ex_is_load(o_ex_is_load),
        .o_ex_ctrl(o_ex_ctrl), .o_hazard_cnt(o_hazard_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_id(input logic vld, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic we, input logic ld,
                          input logic [31:0] imm);
        i_id_valid = vld; i_id_pc = pc;
        i_id_rs1_addr = rs1; i_id_uses_rs1 = u1;
        i_id_rs2_addr = rs2; i_id_uses_rs2 = u2;
        i_id_rd_addr = rd; i_id_rd_we = we; i_id_is_load = ld;
        i_id_imm = imm; i_id_ctrl = pc[15:0] ^ 16'h5A5A;
        #1;
    endtask

    initial begin
        i_rstn = 1'b0;
        set_id(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        i_rs1data = 32'h0; i_rs2data = 32'h0;
        i_mem_rd_addr = 5'd0; i_mem_rd_we = 1'b0; i_mem_rd_data = 32'h0;
        i_wb_rd_addr = 5'd0; i_wb_we = 1'b0; i_wb_rd_data = 32'h0;
        i_ex_rd_data = 32'h0; i_ex_stall = 1'b0; i_flush = 1'b0;
        repeat (2) step();
        check("rst_valid", {31'd0, o_ex_valid}, 32'd0);
        check("rst_cnt", {16'd0, o_hazard_cnt}, 32'd0);
        check("rst_pc", o_ex_pc, 32'd0);
        check("rst_ctrl", {16'd0, o_ex_ctrl}, 32'd0);
        i_rstn = 1'b1;
        step();

        // Back-to-back ALU dependency: addi x5 then reader of x5
        set_id(1'b1, 32'h10, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 32'h10);
        step();
        check("alu_prod_valid", {31'd0, o_ex_valid}, 32'd1);
        set_id(1'b1, 32'h14, 5'd5, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0, 32'h4);
        i_ex_rd_data = 32'h10; i_rs1data = 32'h0;
        check("rf_addr_copy", {27'd0, o_rs1_addr}, 32'd5);
        check("alu_no_stall", {31'd0, o_id_stall}, 32'd0);
        step();
        check("alu_fwd_rs1", o_ex_rs1data, 32'h10);
        check("alu_pc", o_ex_pc, 32'h14);
        check("alu_ctrl", {16'd0, o_ex_ctrl}, {16'd0, 16'h0014 ^ 16'h5A5A});

        // MEM beats WB, WB beats regfile
        set_id(1'b1, 32'h18, 5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0);
        i_mem_rd_addr = 5'd7; i_mem_rd_we = 1'b1; i_mem_rd_data = 32'hAA;
        i_wb_rd_addr = 5'd7; i_wb_we = 1'b1; i_wb_rd_data = 32'hBB;
        i_rs1data = 32'h11; i_rs2data = 32'h22;
        step();
        check("prio_mem", o_ex_rs1data, 32'hAA);
        i_mem_rd_we = 1'b0;
        step();
        check("prio_wb", o_ex_rs2data, 32'hBB);
        i_wb_we = 1'b0;
        step();
        check("prio_rf1", o_ex_rs1data, 32'h11);
        check("prio_rf2", o_ex_rs2data, 32'h22);

        // Load-use on rs2
        set_id(1'b1, 32'h20, 5'd1, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 32'h0);
        step();
        set_id(1'b1, 32'h24, 5'd1, 1'b0, 5'd3, 1'b0, 5'd4, 1'b1, 1'b0, 32'h0);
        check("lu_unused_nostall", {31'd0, o_id_stall}, 32'd0);
        i_id_uses_rs2 = 1'b1; #1;
        check("lu_stall", {31'd0, o_id_stall}, 32'd1);
        step();
        check("lu_bubble", {31'd0, o_ex_valid}, 32'd0);
        check("lu_cnt", {16'd0, o_hazard_cnt}, 32'd1);
        i_mem_rd_addr = 5'd3; i_mem_rd_we = 1'b1; i_mem_rd_data = 32'hDEADBEEF;
        i_rs2data = 32'h0; #1;
        check("lu_release", {31'd0, o_id_stall}, 32'd0);
        step();
        check("lu_mem_fwd", o_ex_rs2data, 32'hDEADBEEF);
        check("lu_valid", {31'd0, o_ex_valid}, 32'd1);
        i_mem_rd_we = 1'b0;

        // x0: load to x0 in EX, then ALU write to x0 in EX
        set_id(1'b1, 32'h30, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 32'h0);
        step();
        set_id(1'b1, 32'h34, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 32'h0);
        i_ex_rd_data = 32'h55; i_rs1data = 32'h99; i_rs2data = 32'h99; #1;
        check("x0_load_nostall", {31'd0, o_id_stall}, 32'd0);
        step();
        check("x0_rs1", o_ex_rs1data, 32'h0);
        check("x0_rs2", o_ex_rs2data, 32'h0);
        set_id(1'b1, 32'h38, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        step();
        check("x0_alu_rs1", o_ex_rs1data, 32'h0);

        // Flush wins over hazard and stall
        set_id(1'b1, 32'h40, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 32'h0);
        step();
        set_id(1'b1, 32'h44, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 32'h0);
        i_ex_stall = 1'b1; i_flush = 1'b1; #1;
        check("flush_nostall", {31'd0, o_id_stall}, 32'd0);
        step();
        check("flush_valid", {31'd0, o_ex_valid}, 32'd0);
        check("flush_cnt", {16'd0, o_hazard_cnt}, 32'd1);
        i_flush = 1'b0; i_ex_stall = 1'b0;

        // Hold for 3 stalled cycles while ID changes
        set_id(1'b1, 32'h100, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 32'h123);
        step();
        i_ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 32'h200 + i, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b0, 1'b0, 32'h777);
            check("hold_stall", {31'd0, o_id_stall}, 32'd1);
            step();
            check("hold_valid", {31'd0, o_ex_valid}, 32'd1);
            check("hold_pc", o_ex_pc, 32'h100);
            check("hold_imm", o_ex_imm, 32'h123);
            check("hold_rd", {27'd0, o_ex_rd_addr}, 32'd9);
        end
        i_ex_stall = 1'b0;

        // Saturation: preset near the top, then alternate load capture / bubble
        force dut.hazard_cnt = 16'hFFFC;
        #1;
        release dut.hazard_cnt;
        set_id(1'b1, 32'h300, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 32'h0);
        step();
        step();
        step();
        step();
        check("sat_fffe", {16'd0, o_hazard_cnt}, 32'h0000FFFE);
        for (int i = 0; i < 3; i++) begin
            step();
            step();
            check("sat_ffff", {16'd0, o_hazard_cnt}, 32'h0000FFFF);
        end

        // Async reset mid-stream with a load sitting in EX
        step();
        check("pre_rst_valid", {31'd0, o_ex_valid}, 32'd1);
        #2;
        i_rstn = 1'b0;
        #1;
        check("async_valid", {31'd0, o_ex_valid}, 32'd0);
        check("async_cnt", {16'd0, o_hazard_cnt}, 32'd0);
        check("async_pc", o_ex_pc, 32'd0);
        check("async_load", {31'd0, o_ex_is_load}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
